// File: rtl/dmem_array_loader.sv
// dmem_array_loader: preloads NUM_ELEMS 64-bit elements into a byte-addressed
// data memory as little-endian byte writes, holding the core in reset until
// the whole array has been written.
// Optional feature macro: DMEM_LOADER_CHECKSUM_EN (running 64-bit element sum).
//
// Handshake: an element transfers on a rising edge where in_valid && in_ready;
// in_ready is high only in ACCEPT and the producer must hold in_data stable
// while in_valid is high and in_ready is low.
// dbg_state exposes the FSM state register for observation.
module dmem_array_loader #(
    parameter int NUM_ELEMS  = 8,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [63:0]           in_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            count,
    output logic [63:0]           checksum,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(NUM_ELEMS);

    state_t                state_q, state_d;
    logic [63:0]           elem_q, elem_d;
    logic [2:0]            byte_idx_q, byte_idx_d;
    logic [3:0]            count_q, count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  core_reset_q, core_reset_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [31:0]           elem_addr;
    logic [31:0]           byte_addr;
    logic [2:0]            next_idx;

    // Byte address of the current element's byte 0, at full precision.
    assign elem_addr = 32'(BASE_ADDR) + {25'd0, count_q, 3'b000};
    assign next_idx  = byte_idx_q + 3'd1;

    assign in_ready   = (state_q == ACCEPT);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign count      = count_q;
    assign dbg_state  = state_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        byte_idx_d   = byte_idx_q;
        count_d      = count_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        byte_addr    = elem_addr;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = ACCEPT;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    core_reset_d = 1'b1;
                    count_d      = 4'd0;
                end
            end
            ACCEPT: begin
                // Byte 0 is issued straight from in_data so it appears in the
                // cycle right after the handshake edge.
                if (in_valid) begin
                    elem_d      = in_data;
                    byte_idx_d  = 3'd0;
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = elem_addr[ADDR_WIDTH-1:0];
                    mem_wdata_d = in_data[7:0];
                end
            end
            WRITE: begin
                if (byte_idx_q == 3'd7) begin
                    count_d = count_q + 4'd1;
                    if (count_q + 4'd1 == LAST_COUNT) begin
                        state_d      = DONE;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d = ACCEPT;
                    end
                end else begin
                    byte_idx_d  = next_idx;
                    byte_addr   = elem_addr + {29'd0, next_idx};
                    mem_we_d    = 1'b1;
                    mem_addr_d  = byte_addr[ADDR_WIDTH-1:0];
                    mem_wdata_d = elem_q[{next_idx, 3'b000} +: 8];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            elem_q       <= 64'd0;
            byte_idx_q   <= 3'd0;
            count_q      <= 4'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            byte_idx_q   <= byte_idx_d;
            count_q      <= count_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [63:0] checksum_q;
    logic        hs;
    logic        load_start;

    assign hs         = in_ready && in_valid;
    assign load_start = ((state_q == IDLE) || (state_q == DONE)) && start;
    assign checksum   = checksum_q;

    // Wrapping sum of accepted elements, cleared when a load starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= 64'd0;
        end else if (load_start) begin
            checksum_q <= 64'd0;
        end else if (hs) begin
            checksum_q <= checksum_q + in_data;
        end
    end
`else
    assign checksum = 64'd0;
`endif

endmodule

// File: tb/tb_dmem_array_loader.sv
module tb_dmem_array_loader;

    localparam int NUM_ELEMS  = 8;
    localparam int BASE_ADDR  = 0;
    localparam int ADDR_WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic                  in_valid = 1'b0;
    logic [63:0]           in_data = 64'd0;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  core_reset;
    logic                  busy;
    logic                  done;
    logic [3:0]            count;
    logic [63:0]           checksum;
    logic [1:0]            dbg_state;

    dmem_array_loader #(
        .NUM_ELEMS (NUM_ELEMS),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_reset(core_reset),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .checksum  (checksum),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {in_ready, mem_we, core_reset, busy, done, count}
    wire [8:0] status = {in_ready, mem_we, core_reset, busy, done, count};

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    // Entry: {expected cycle[31:0], addr[7:0], data[7:0]}
    logic [47:0] exp_q[$];
    logic [7:0]  dut_mem[256];
    logic [7:0]  model_mem[256];
    logic [63:0] model_sum;
    logic [63:0] elem_tab[NUM_ELEMS];
    logic [47:0] mon_e;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (mem_we === 1'b1) begin
                dut_mem[mem_addr] = mem_wdata;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%02h cycle=%0d, required no write",
                             mem_addr, mem_wdata, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    model_mem[mon_e[15:8]] = mon_e[7:0];
                    if (mon_e[47:16] !== 32'(cyc) || mon_e[15:8] !== mem_addr || mon_e[7:0] !== mem_wdata) begin
                        errors++;
                        $display("FAIL byte_write: got cycle=%0d addr=%0d data=%02h, required cycle=%0d addr=%0d data=%02h",
                                 cyc, mem_addr, mem_wdata, mon_e[47:16], mon_e[15:8], mon_e[7:0]);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0][47:16] <= 32'(cyc)) begin
                checks++;
                errors++;
                mon_e = exp_q.pop_front();
                $display("FAIL missed_write: got no write at cycle=%0d, required addr=%0d data=%02h",
                         cyc, mon_e[15:8], mon_e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_start: got in_ready=%b, required 0", in_ready);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_sum = 64'd0;
        checks++;
        if (status !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0} || checksum !== 64'd0) begin
            errors++;
            $display("FAIL after_start: got status=%b checksum=%0h, required status=101100000 checksum=0",
                     status, checksum);
        end
    endtask

    task automatic send_elem(input logic [63:0] d, input int idx, output int hs_cyc);
        int n;
        logic [7:0] a;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        hs_cyc = cyc;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b after %0d cycles, required 1", in_ready, n);
            return;
        end
        for (int b = 0; b < 8; b++) begin
            a = 8'(BASE_ADDR + 8 * idx + b);
            exp_q.push_back({32'(cyc + 1 + b), a, d[8*b +: 8]});
        end
        model_sum = model_sum + d;
        @(negedge clk);
        checks++;
        if (status !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'(idx)}) begin
            errors++;
            $display("FAIL after_handshake: got status=%b, required in_ready=0 mem_we=1 busy=1 count=%0d",
                     status, idx);
        end
    endtask

    task automatic wait_done(input int first_hs, input bit chk_lat);
        int n;
        int mism;
        logic [63:0] exp_cs;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got done=%b, required 1", done);
        end
        if (chk_lat) begin
            checks++;
            if (cyc != first_hs + 72) begin
                errors++;
                $display("FAIL done_latency: got %0d cycles after first handshake, required 72", cyc - first_hs);
            end
        end
`ifdef DMEM_LOADER_CHECKSUM_EN
        exp_cs = model_sum;
`else
        exp_cs = 64'd0;
`endif
        checks++;
        if (status !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(NUM_ELEMS)} || checksum !== exp_cs) begin
            errors++;
            $display("FAIL done_state: got status=%b checksum=%0h, required status=000010%04b checksum=%0h",
                     status, checksum, 4'(NUM_ELEMS), exp_cs);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: got %0d writes outstanding, required 0", exp_q.size());
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (dut_mem[i] !== model_mem[i]) mism++;
        checks++;
        if (mism != 0) begin
            errors++;
            $display("FAIL memory_image: got %0d differing bytes, required 0", mism);
        end
    endtask

    task automatic run_load(input int gap_idx, input int start_idx, input bit chk_lat);
        int hs;
        int first;
        int n;
        first = 0;
        do_start();
        for (int i = 0; i < NUM_ELEMS; i++) begin
            if (i == gap_idx) begin
                in_valid = 1'b0;
                n = 0;
                while (in_ready !== 1'b1 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                for (int g = 0; g < 3; g++) begin
                    checks++;
                    if (status !== {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'(i)}) begin
                        errors++;
                        $display("FAIL gap_idle: got status=%b, required in_ready=1 mem_we=0 count=%0d", status, i);
                    end
                    @(negedge clk);
                end
            end
            send_elem(elem_tab[i], i, hs);
            if (i == 0) first = hs;
            if (i == start_idx) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (status !== {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'(i)}) begin
                    errors++;
                    $display("FAIL start_ignored: got status=%b, required mem_we=1 busy=1 done=0 count=%0d", status, i);
                end
            end
        end
        wait_done(first, chk_lat && gap_idx < 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_ELEMS; i++) elem_tab[i] = {$urandom, $urandom};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (status !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0} || checksum !== 64'd0 ||
            mem_addr !== 8'd0 || mem_wdata !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: got status=%b checksum=%0h addr=%0d wdata=%02h, required status=001000000 rest 0",
                     status, checksum, mem_addr, mem_wdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_single_format();
        fill_random();
        elem_tab[0] = 64'h0807060504030201;
        run_load(-1, -1, 1'b1);
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (dut_mem[b] !== 8'(b + 1)) begin
                errors++;
                $display("FAIL le_byte: got mem[%0d]=%02h, required %02h", b, dut_mem[b], 8'(b + 1));
            end
        end
    endtask

    task automatic test_full_load();
        for (int i = 0; i < NUM_ELEMS; i++) elem_tab[i] = 64'(8 - i);
        run_load(-1, -1, 1'b1);
        for (int i = 0; i < NUM_ELEMS; i++) begin
            checks++;
            if (dut_mem[8*i] !== 8'(8 - i)) begin
                errors++;
                $display("FAIL full_load_byte: got mem[%0d]=%02h, required %02h", 8 * i, dut_mem[8*i], 8'(8 - i));
            end
        end
`ifdef DMEM_LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 64'd36) begin
            errors++;
            $display("FAIL full_load_checksum: got %0d, required 36", checksum);
        end
`endif
    endtask

    task automatic test_backpressure();
        fill_random();
        run_load(2, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_load(-1, 3, 1'b1);
    endtask

    task automatic test_reset_mid_write();
        int hs;
        fill_random();
        do_start();
        for (int i = 0; i < 3; i++) send_elem(elem_tab[i], i, hs);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (status !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0} || checksum !== 64'd0 || mem_addr !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got status=%b checksum=%0h addr=%0d, required status=001000000 checksum=0 addr=0",
                     status, checksum, mem_addr);
        end
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        fill_random();
        run_load(-1, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_load(int'($urandom_range(0, NUM_ELEMS - 1)), int'($urandom_range(0, NUM_ELEMS - 1)), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dut_mem[i]   = 8'd0;
            model_mem[i] = 8'd0;
        end
        model_sum = 64'd0;
        test_reset();
        test_single_format();
        test_full_load();
        test_backpressure();
        test_start_ignored();
        test_reset();
        test_reset_mid_write();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
